// File: rtl/yas_router_pkg.sv
// Shared definitions for the router transmit path: data/length widths,
// header field positions and the transmit FSM state encoding.
package yas_router_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DATA_SIZE  = 6;

  localparam int unsigned ADDR_MSB = 7;
  localparam int unsigned ADDR_LSB = 6;
  localparam int unsigned LEN_MSB  = 5;
  localparam int unsigned LEN_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } tx_state_e;

endpackage

// File: rtl/pkt_credit_cnt.sv
// Up/down counter of packets committed to the FIFO but not yet sent.
// Saturates at both ends; sat flags the all-ones value.
module pkt_credit_cnt #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             nonzero,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != MAX) count <= count + WIDTH'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - WIDTH'(1);
    end
  end

  assign nonzero = (count != '0);
  assign sat     = (count == MAX);

endmodule

// File: rtl/channel_tx.sv
// Packet transmitter: drains committed packets from a fall-through FIFO and
// presents them byte by byte on a req/ack output port.
module channel_tx #(
  parameter int unsigned DATA_WIDTH    = yas_router_pkg::DATA_WIDTH,
  parameter int unsigned DATA_SIZE     = yas_router_pkg::DATA_SIZE,
  parameter int unsigned PKT_CNT_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_commit,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_req,
  input  logic                  data_out_ack,
  output logic                  busy,
  output logic                  pkt_sent
);
  import yas_router_pkg::*;

  tx_state_e              state, state_next;
  logic [DATA_WIDTH-1:0]  data_q, data_next;
  logic                   req_q, req_next;
  logic [DATA_SIZE-1:0]   rem_q, rem_next;
  logic                   sent_q, sent_next;
  logic                   busy_q, busy_next;
  logic                   pop;

  logic [PKT_CNT_WIDTH-1:0] pkt_cnt;
  logic                     cnt_nonzero;
  logic                     cnt_sat;

  pkt_credit_cnt #(.WIDTH(PKT_CNT_WIDTH)) u_credit (
    .clk     (clk),
    .rst     (rst),
    .inc     (pkt_commit),
    .dec     (state == GAP),
    .count   (pkt_cnt),
    .nonzero (cnt_nonzero),
    .sat     (cnt_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      req_q  <= 1'b0;
      rem_q  <= '0;
      sent_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      data_q <= data_next;
      req_q  <= req_next;
      rem_q  <= rem_next;
      sent_q <= sent_next;
      busy_q <= busy_next;
    end
  end

  // rem counts payload bytes not yet acknowledged, including the one on data_out.
  // req_q=0 outside IDLE/GAP means a stall waiting on the FIFO for the next byte.
  always_comb begin
    state_next = state;
    data_next  = data_q;
    req_next   = req_q;
    rem_next   = rem_q;
    sent_next  = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (cnt_nonzero && !fifo_empty) begin
          pop        = 1'b1;
          data_next  = fifo_data;
          req_next   = 1'b1;
          rem_next   = fifo_data[LEN_LSB +: DATA_SIZE];
          state_next = HDR;
        end
      end
      HDR: begin
        if (req_q && data_out_ack) begin
          if (rem_q == '0) begin
            req_next   = 1'b0;
            sent_next  = 1'b1;
            state_next = GAP;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            data_next  = fifo_data;
            state_next = PAYLOAD;
          end else begin
            req_next = 1'b0;
          end
        end else if (!req_q && !fifo_empty) begin
          pop        = 1'b1;
          data_next  = fifo_data;
          req_next   = 1'b1;
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (req_q && data_out_ack) begin
          rem_next = rem_q - DATA_SIZE'(1);
          if (rem_q == DATA_SIZE'(1)) begin
            req_next   = 1'b0;
            sent_next  = 1'b1;
            state_next = GAP;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            data_next = fifo_data;
          end else begin
            req_next = 1'b0;
          end
        end else if (!req_q && !fifo_empty) begin
          pop       = 1'b1;
          data_next = fifo_data;
          req_next  = 1'b1;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  assign fifo_pop     = pop;
  assign data_out     = data_q;
  assign data_out_req = req_q;
  assign busy         = busy_q;
  assign pkt_sent     = sent_q;

  // A commit with the counter full and no completion that cycle loses a packet.
  a_no_commit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(pkt_commit && cnt_sat && (state != GAP)));

  a_busy_has_credit: assert property (@(posedge clk) disable iff (rst)
    (state != IDLE) |-> (pkt_cnt != '0));

endmodule

// File: tb/tb_channel_tx.sv
// Self-checking bench for channel_tx: a FIFO model feeds packets, a monitor
// compares every transfer against the pushed byte stream and packet lengths.
module tb_channel_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pkt_commit = 1'b0;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] data_out;
  logic       data_out_req;
  logic       data_out_ack = 1'b1;
  logic       busy;
  logic       pkt_sent;

  always #5 clk = ~clk;

  channel_tx #(.DATA_WIDTH(8), .DATA_SIZE(6), .PKT_CNT_WIDTH(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_commit   (pkt_commit),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_pop     (fifo_pop),
    .data_out     (data_out),
    .data_out_req (data_out_req),
    .data_out_ack (data_out_ack),
    .busy         (busy),
    .pkt_sent     (pkt_sent)
  );

  // FIFO model: fmem doubles as the log of every byte ever pushed.
  logic [7:0]  fmem [0:4095];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic        flush = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = fmem[rd_ptr % 4096];

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_pop) rd_ptr <= rd_ptr + 1;
  end

  // Reference model state: each packet is LEN+1 bytes, bytes leave in push order.
  int unsigned plen [0:255];
  int unsigned plen_wr = 0, plen_rd = 0;
  int unsigned exp_rd = 0, cur_rem = 0;
  bit          sent_due = 1'b0;
  int unsigned gap = 0;
  int unsigned cyc = 0, pop_cnt = 0, commit_cyc = 0;
  int unsigned xfer_cyc [$];
  logic [7:0]  xfer_byte [$];
  int unsigned sent_cyc [$];
  int unsigned ack_mode = 0;

  int unsigned n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic monitor();
    logic       prev_req = 1'b0, prev_ack = 1'b0;
    logic [7:0] prev_data = '0;
    bit         exp_sent;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_rd = wr_ptr; cur_rem = 0; plen_rd = plen_wr;
        sent_due = 1'b0; gap = 0; prev_req = 1'b0; prev_ack = 1'b0;
        continue;
      end
      if (pkt_commit) commit_cyc = cyc;
      if (fifo_pop) begin
        pop_cnt++;
        chk("pop_nonempty", fifo_empty, 1'b0);
      end
      if (pkt_sent) sent_cyc.push_back(cyc);
      exp_sent = sent_due;
      sent_due = 1'b0;
      if (exp_sent) gap = 2;
      chk("pkt_sent", pkt_sent, exp_sent);
      if (gap > 0) begin
        chk("gap_req_low", data_out_req, 1'b0);
        gap--;
      end
      if (prev_req && !prev_ack) begin
        chk("hold_req", data_out_req, 1'b1);
        chk("hold_data", data_out, prev_data);
      end
      if (data_out_req && !data_out_ack) chk("stall_no_pop", fifo_pop, 1'b0);
      if (data_out_req) chk("busy_with_req", busy, 1'b1);
      if (data_out_req && data_out_ack) begin
        if (exp_rd == wr_ptr || (cur_rem == 0 && plen_rd == plen_wr)) begin
          chk("unexpected_xfer", 32'd1, 32'd0);
        end else begin
          chk("xfer_data", data_out, fmem[exp_rd % 4096]);
          exp_rd++;
          if (cur_rem == 0) begin
            cur_rem = plen[plen_rd % 256];
            plen_rd++;
          end
          cur_rem--;
          if (cur_rem == 0) sent_due = 1'b1;
        end
        xfer_cyc.push_back(cyc);
        xfer_byte.push_back(data_out);
      end
      prev_req  = data_out_req;
      prev_ack  = data_out_ack;
      prev_data = data_out;
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      case (ack_mode)
        0: data_out_ack = 1'b1;
        1: data_out_ack = ($urandom_range(0, 3) != 0);
        default: data_out_ack = 1'b0;
      endcase
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fmem[wr_ptr % 4096] = b;
    wr_ptr++;
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] base, input logic [7:0] stepv);
    logic [7:0] b;
    plen[plen_wr % 256] = 32'(hdr[5:0]) + 1;
    plen_wr++;
    push_byte(hdr);
    b = base;
    for (int unsigned i = 0; i < 32'(hdr[5:0]); i++) begin
      push_byte(b);
      b = b + stepv;
    end
  endtask

  task automatic commit();
    pkt_commit = 1'b1;
    step(1);
    pkt_commit = 1'b0;
  endtask

  task automatic wait_sent(input int unsigned target, input string name);
    int unsigned n = 0;
    while (sent_cyc.size() < target && n < 300) begin
      step(1);
      n++;
    end
    chk(name, 32'(sent_cyc.size() >= target), 32'd1);
  endtask

  initial begin
    int unsigned xb, sb, pb, n;
    logic [7:0] hdr;
    int unsigned len;

    fork monitor(); join_none

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_req", data_out_req, 1'b0);
    chk("rst_pop", fifo_pop, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sent", pkt_sent, 1'b0);
    step(2);
    rst = 1'b0;
    step(2);

    // Header 0x43 with payload A1 A2 A3, ack high.
    xb = xfer_byte.size(); sb = sent_cyc.size(); pb = pop_cnt;
    push_pkt(8'h43, 8'hA1, 8'h01);
    commit();
    wait_sent(sb + 1, "p1_done");
    chk("p1_b0", xfer_byte[xb],   8'h43);
    chk("p1_b1", xfer_byte[xb+1], 8'hA1);
    chk("p1_b2", xfer_byte[xb+2], 8'hA2);
    chk("p1_b3", xfer_byte[xb+3], 8'hA3);
    chk("p1_latency", xfer_cyc[xb] - commit_cyc, 32'd2);
    chk("p1_back_to_back", xfer_cyc[xb+3] - xfer_cyc[xb], 32'd3);
    chk("p1_sent_time", sent_cyc[sb] - xfer_cyc[xb+3], 32'd1);
    chk("p1_pops", pop_cnt - pb, 32'd4);
    step(2);
    chk("p1_cnt_zero", 32'(dut.pkt_cnt), 32'd0);
    chk("p1_idle_busy", busy, 1'b0);

    // Header-only packet 0x80.
    xb = xfer_byte.size(); sb = sent_cyc.size(); pb = pop_cnt;
    push_pkt(8'h80, 8'h00, 8'h00);
    commit();
    wait_sent(sb + 1, "p2_done");
    chk("p2_b0", xfer_byte[xb], 8'h80);
    chk("p2_one_xfer", xfer_byte.size() - xb, 32'd1);
    chk("p2_pops", pop_cnt - pb, 32'd1);
    step(1);
    chk("p2_cnt_zero", 32'(dut.pkt_cnt), 32'd0);

    // Packet 02 11 22 with the sink stalling 5 cycles on the header.
    xb = xfer_byte.size(); sb = sent_cyc.size();
    ack_mode = 2; data_out_ack = 1'b0;
    push_pkt(8'h02, 8'h11, 8'h11);
    commit();
    n = 0;
    while (!data_out_req && n < 20) begin step(1); n++; end
    chk("p3_req_rise", data_out_req, 1'b1);
    pb = pop_cnt;
    step(5);
    chk("p3_stall_pops", pop_cnt - pb, 32'd0);
    chk("p3_hold_hdr", data_out, 8'h02);
    ack_mode = 0; data_out_ack = 1'b1;
    wait_sent(sb + 1, "p3_done");
    chk("p3_b0", xfer_byte[xb],   8'h02);
    chk("p3_b1", xfer_byte[xb+1], 8'h11);
    chk("p3_b2", xfer_byte[xb+2], 8'h22);

    // Two packets committed on consecutive cycles.
    xb = xfer_byte.size(); sb = sent_cyc.size();
    push_pkt(8'h41, 8'h55, 8'h00);
    push_pkt(8'hC2, 8'h66, 8'h11);
    commit();
    commit();
    chk("p4_cnt_two", 32'(dut.pkt_cnt), 32'd2);
    wait_sent(sb + 2, "p4_done");
    chk("p4_b0", xfer_byte[xb],   8'h41);
    chk("p4_b2", xfer_byte[xb+2], 8'hC2);
    chk("p4_b4", xfer_byte[xb+4], 8'h77);
    chk("p4_spacing", xfer_cyc[xb+2] - xfer_cyc[xb+1], 32'd3);

    // Commit landing on the GAP cycle of the previous packet.
    xb = xfer_byte.size(); sb = sent_cyc.size();
    push_pkt(8'h01, 8'h99, 8'h00);
    push_pkt(8'h00, 8'h00, 8'h00);
    commit();
    n = 0;
    while (!pkt_sent && n < 20) begin step(1); n++; end
    chk("p5_gap_seen", pkt_sent, 1'b1);
    pkt_commit = 1'b1;
    chk("p5_cnt_in_gap", 32'(dut.pkt_cnt), 32'd1);
    step(1);
    pkt_commit = 1'b0;
    chk("p5_cnt_unchanged", 32'(dut.pkt_cnt), 32'd1);
    wait_sent(sb + 2, "p5_done");
    chk("p5_b2", xfer_byte[xb+2], 8'h00);
    chk("p5_spacing", xfer_cyc[xb+2] - xfer_cyc[xb+1], 32'd3);
    step(2);
    chk("p5_cnt_zero", 32'(dut.pkt_cnt), 32'd0);

    // Reset on the 2nd payload byte of a LEN=5 packet.
    push_pkt(8'h05, 8'hB1, 8'h01);
    commit();
    n = 0;
    while (!(data_out_req && data_out == 8'hB2) && n < 20) begin step(1); n++; end
    chk("p6_reached_b2", data_out, 8'hB2);
    #2 rst = 1'b1;
    #1;
    chk("p6_rst_data", data_out, 8'h00);
    chk("p6_rst_req", data_out_req, 1'b0);
    chk("p6_rst_pop", fifo_pop, 1'b0);
    chk("p6_rst_busy", busy, 1'b0);
    chk("p6_rst_sent", pkt_sent, 1'b0);
    chk("p6_rst_cnt", 32'(dut.pkt_cnt), 32'd0);
    chk("p6_rst_rem", 32'(dut.rem_q), 32'd0);
    chk("p6_rst_state", 32'(dut.state), 32'd0);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(1);
    rst = 1'b0;
    xb = xfer_byte.size(); sb = sent_cyc.size();
    push_pkt(8'h01, 8'h33, 8'h00);
    for (int unsigned i = 0; i < 8; i++) begin
      step(1);
      chk("p6_no_req_before_commit", data_out_req, 1'b0);
    end
    commit();
    wait_sent(sb + 1, "p6_done");
    chk("p6_b0", xfer_byte[xb],   8'h01);
    chk("p6_b1", xfer_byte[xb+1], 8'h33);

    // Randomized traffic with a random sink and occasional early commits.
    ack_mode = 1;
    for (int unsigned p = 0; p < 40; p++) begin
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(8, 63);
      hdr = {2'($urandom_range(0, 3)), 6'(len)};
      if ($urandom_range(0, 4) == 0) begin
        plen[plen_wr % 256] = len + 1;
        plen_wr++;
        push_byte(hdr);
        commit();
        for (int unsigned i = 0; i < len; i++) begin
          step($urandom_range(0, 2));
          push_byte(8'($urandom));
        end
      end else begin
        plen[plen_wr % 256] = len + 1;
        plen_wr++;
        push_byte(hdr);
        for (int unsigned i = 0; i < len; i++) push_byte(8'($urandom));
        commit();
      end
      step($urandom_range(0, 3));
    end
    n = 0;
    while (exp_rd != wr_ptr && n < 5000) begin step(1); n++; end
    chk("rand_drained", 32'(exp_rd == wr_ptr), 32'd1);
    step(3);
    chk("rand_all_pkts", plen_rd, plen_wr);
    chk("rand_cnt_zero", 32'(dut.pkt_cnt), 32'd0);
    chk("rand_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
